// File: rtl/three_bit_down_counter.sv
// Falling-edge down counter with async active-high clear to all-ones, optional wrap or saturate.
// Parallel load is compiled in only when DOWNCOUNTER_PRELOAD_EN is defined.
module three_bit_down_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qbar_o,
  output logic             zero_o,
  output logic             borrow_o
);

  localparam logic [WIDTH-1:0] AllOnes = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q;
  logic [WIDTH-1:0] dec;
  logic             zero;

  assign zero = (q_q == '0);

  // Saturating build holds at zero instead of wrapping to all-ones.
  assign dec = (SATURATE && zero) ? q_q : q_q - WIDTH'(1);

`ifdef DOWNCOUNTER_PRELOAD_EN
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (en_i) begin
      q_d = dec;
    end
  end
`else
  logic unused_load;
  assign unused_load = ^{load_i, d_i};

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = dec;
    end
  end
`endif

  // Qbar has its own flop so it is registered alongside Q rather than derived after it.
  always_ff @(negedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      q_q    <= AllOnes;
      qbar_q <= '0;
    end else begin
      q_q    <= q_d;
      qbar_q <= ~q_d;
    end
  end

  assign q_o      = q_q;
  assign qbar_o   = qbar_q;
  assign zero_o   = zero & ~clr_i;
  assign borrow_o = en_i & zero & ~clr_i;

endmodule
